// File: rtl/maple_pkg.sv
// Shared definitions for the Maple bus receive path.
//   rx_state_e     : receiver FSM states
//   START_PULSES   : pin5 falls expected inside a start pattern
//   END_PULSES     : pin1 falls expected inside an end pattern
//   PIN5_SLOT_MASK : bit positions carried on pin5 (the rest ride on pin1);
//                    same slot order the transmit stage uses
//   shift_in()     : MSB-first accumulate of one bit
package maple_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA_A = 3'd2,
        DATA_B = 3'd3,
        END    = 3'd4
    } rx_state_e;

    localparam logic [2:0] START_PULSES = 3'd4;
    localparam logic [2:0] END_PULSES   = 3'd2;

    // Bits 7,5,3,1 are sampled from pin5 while pin1 clocks; bits 6,4,2,0 the other way round.
    localparam logic [7:0] PIN5_SLOT_MASK = 8'hAA;

    function automatic logic [7:0] shift_in(input logic [7:0] acc, input logic b);
        return {acc[6:0], b};
    endfunction

endpackage

// File: rtl/maple_edge_sync.sv
// Input synchronizer plus edge detector for one raw Maple bus line.
//   clk     : system clock
//   rst_n   : async active-low reset; chain presets to 1 (idle bus)
//   line_i  : raw asynchronous bus line
//   level_o : synchronized level
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition
//   fall_o  : one-cycle pulse on a synchronized 1->0 transition
module maple_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/maple_in.sv
// Maple bus receiver: decodes start/end patterns and MSB-first data bytes
// from the two bus lines and hands bytes to the receive FIFO.
//   clk          : system clock
//   rst_n        : async active-low reset
//   pin1, pin5   : raw bus lines SDCKA / SDCKB (asynchronous)
//   enable       : receiver armed (transmitter has released the bus)
//   fifo_full    : receive FIFO cannot accept a byte
//   fifo_data    : last received byte
//   fifo_write   : one-cycle write strobe for fifo_data
//   frame_start  : one-cycle pulse, start pattern accepted
//   frame_end    : one-cycle pulse, end pattern accepted
//   rx_busy      : receiver is outside IDLE
//   err_framing  : sticky protocol error, cleared by the next frame_start
//   err_overflow : sticky dropped-byte flag, cleared by the next frame_start
//
// state  | meaning
// IDLE   | waiting for pin1 to fall while pin5 is high
// START  | counting pin5 falls while pin1 is low
// DATA_A | pin1 is the clock; its fall samples pin5
// DATA_B | pin5 is the clock; its fall samples pin1
// END    | counting pin1 falls while pin5 is low
module maple_in
    import maple_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pin1,
    input  logic       pin5,
    input  logic       enable,
    input  logic       fifo_full,
    output logic [7:0] fifo_data,
    output logic       fifo_write,
    output logic       frame_start,
    output logic       frame_end,
    output logic       rx_busy,
    output logic       err_framing,
    output logic       err_overflow
);

    logic p1_lvl, p1_rise, p1_fall;
    logic p5_lvl, p5_rise, p5_fall;

    maple_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pin1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (pin1),
        .level_o (p1_lvl),
        .rise_o  (p1_rise),
        .fall_o  (p1_fall)
    );

    maple_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pin5 (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (pin5),
        .level_o (p5_lvl),
        .rise_o  (p5_rise),
        .fall_o  (p5_fall)
    );

    rx_state_e       state_q, state_d;
    logic [2:0]      pulse_q, pulse_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            wr_q, wr_d;
    logic            fs_q, fs_d;
    logic            fe_q, fe_d;
    logic            ef_q, ef_d;
    logic            eo_q, eo_d;
    logic [TO_W-1:0] to_q, to_d;

    logic any_edge, both_edge, timeout_hit, do_shift, sample_bit;

    assign any_edge    = p1_rise | p1_fall | p5_rise | p5_fall;
    assign both_edge   = (p1_rise | p1_fall) & (p5_rise | p5_fall);
    assign timeout_hit = (to_q == TO_W'(TIMEOUT_CYCLES - 1)) && !any_edge;
    // Which line carries the current bit follows from its slot position.
    assign sample_bit  = PIN5_SLOT_MASK[3'd7 - bit_q] ? p5_lvl : p1_lvl;

    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        wr_d     = 1'b0;
        fs_d     = 1'b0;
        fe_d     = 1'b0;
        ef_d     = ef_q;
        eo_d     = eo_q;
        to_d     = '0;
        do_shift = 1'b0;

        if (state_q != IDLE && !any_edge) begin
            to_d = to_q + TO_W'(1);
        end

        if (state_q != IDLE && !enable) begin
            // Transmitter took the bus back: silent abort.
            state_d = IDLE;
        end else if (state_q != IDLE && (both_edge || timeout_hit)) begin
            ef_d    = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && p1_fall && p5_lvl) begin
                        state_d = START;
                        pulse_d = '0;
                    end
                end
                START: begin
                    if (p1_rise) begin
                        if (pulse_q == START_PULSES) begin
                            state_d = DATA_A;
                            fs_d    = 1'b1;
                            ef_d    = 1'b0;
                            eo_d    = 1'b0;
                            bit_d   = '0;
                        end else begin
                            ef_d    = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (p5_fall && !p1_lvl && pulse_q != 3'd7) begin
                        pulse_d = pulse_q + 3'd1;
                    end
                end
                DATA_A: begin
                    if (p1_fall) begin
                        do_shift = 1'b1;
                        state_d  = DATA_B;
                    end else if (p5_fall) begin
                        // Only a byte boundary with pin1 high may open an end pattern.
                        if (p1_lvl && bit_q == 3'd0) begin
                            state_d = END;
                            pulse_d = '0;
                        end else begin
                            ef_d    = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                DATA_B: begin
                    if (p5_fall) begin
                        do_shift = 1'b1;
                        state_d  = DATA_A;
                    end
                end
                END: begin
                    if (p5_rise) begin
                        if (pulse_q == END_PULSES) begin
                            fe_d = 1'b1;
                        end else begin
                            ef_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else if (p1_fall && !p5_lvl && pulse_q != 3'd7) begin
                        pulse_d = pulse_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (do_shift) begin
            shift_d = shift_in(shift_q, sample_bit);
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
                if (fifo_full) begin
                    eo_d = 1'b1;
                end else begin
                    wr_d   = 1'b1;
                    data_d = shift_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pulse_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
            ef_q    <= 1'b0;
            eo_q    <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
            ef_q    <= ef_d;
            eo_q    <= eo_d;
            to_q    <= to_d;
        end
    end

    assign fifo_data    = data_q;
    assign fifo_write   = wr_q;
    assign frame_start  = fs_q;
    assign frame_end    = fe_q;
    assign rx_busy      = (state_q != IDLE);
    assign err_framing  = ef_q;
    assign err_overflow = eo_q;

endmodule

// File: tb/tb_maple_in.sv
module tb_maple_in;

    localparam int SLOT    = 8;
    localparam int TIMEOUT = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin1 = 1'b1;
    logic       pin5 = 1'b1;
    logic       enable = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] fifo_data;
    logic       fifo_write, frame_start, frame_end, rx_busy, err_framing, err_overflow;

    maple_in dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pin1         (pin1),
        .pin5         (pin5),
        .enable       (enable),
        .fifo_full    (fifo_full),
        .fifo_data    (fifo_data),
        .fifo_write   (fifo_write),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .rx_busy      (rx_busy),
        .err_framing  (err_framing),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: bytes that should reach the FIFO and pulse counts.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int exp_fs = 0, exp_fe = 0;
    int fs_cnt = 0, fe_cnt = 0;
    logic [7:0] fb[4];
    int full_at = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_write || frame_start || frame_end)
                check("strobe_exclusive",
                      32'(int'(fifo_write) + int'(frame_start) + int'(frame_end)), 32'd1);
            if (fifo_write) got_q.push_back(fifo_data);
            if (frame_start) fs_cnt++;
            if (frame_end) begin
                fe_cnt++;
                check("busy_at_frame_end", 32'(rx_busy), 32'd0);
            end
        end
    end

    // One line change, then a full bit slot of settling.
    task automatic drive(input logic a, input logic b);
        pin1 = a;
        pin5 = b;
        repeat (SLOT) @(negedge clk);
    endtask

    task automatic send_start(input int n);
        drive(1'b0, 1'b1);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0);
            if (k < n - 1) drive(1'b0, 1'b1);
        end
        drive(1'b1, 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            int bi;
            bi = 7 - k;
            if (k % 2 == 0) begin
                drive(1'b1, pin5);
                drive(1'b1, b[bi]);
                drive(1'b0, b[bi]);
            end else begin
                drive(pin1, 1'b1);
                drive(b[bi], 1'b1);
                drive(b[bi], 1'b0);
            end
        end
    endtask

    task automatic send_end();
        drive(1'b1, pin5);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
    endtask

    task automatic send_frame(input int nb);
        send_start(4);
        for (int j = 0; j < nb; j++) begin
            fifo_full = (j == full_at);
            send_bits(fb[j], 8);
            fifo_full = 1'b0;
            if (enable && j != full_at) exp_q.push_back(fb[j]);
        end
        send_end();
        if (enable) begin
            exp_fs++;
            exp_fe++;
        end
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_frame_start_count"}, 32'(fs_cnt), 32'(exp_fs));
        check({tag, "_frame_end_count"}, 32'(fe_cnt), 32'(exp_fe));
        check({tag, "_write_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(rx_busy), 32'd0);
        check("reset_outputs",
              32'({fifo_data, fifo_write, frame_start, frame_end, err_framing, err_overflow}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte 0xA5
        fb[0] = 8'hA5;
        send_start(4);
        check("busy_after_start", 32'(rx_busy), 32'd1);
        check("fs_after_start", 32'(fs_cnt), 32'd1);
        exp_fs++;
        send_bits(fb[0], 8);
        exp_q.push_back(fb[0]);
        send_end();
        exp_fe++;
        compare_rx("a5");
        check("a5_fifo_data", 32'(fifo_data), 32'hA5);
        check("a5_errors", 32'({err_framing, err_overflow}), 32'd0);

        // Multi-byte frame with directed extremes plus a random byte
        fb[0] = 8'h00; fb[1] = 8'hFF; fb[2] = 8'h3C; fb[3] = 8'($urandom);
        send_frame(4);
        compare_rx("multi");
        check("multi_busy", 32'(rx_busy), 32'd0);

        // Overflow on the second of two bytes
        fb[0] = 8'($urandom); fb[1] = 8'($urandom);
        full_at = 1;
        send_frame(2);
        full_at = -1;
        compare_rx("ovf");
        check("ovf_flag", 32'(err_overflow), 32'd1);
        check("ovf_no_framing", 32'(err_framing), 32'd0);
        repeat (50) @(negedge clk);
        check("ovf_held", 32'(err_overflow), 32'd1);

        // Wrong start pulse counts on either side of 4
        for (int n = 3; n <= 5; n += 2) begin
            send_start(n);
            drive(1'b1, 1'b1);
            check("bad_start_framing", 32'(err_framing), 32'd1);
            check("bad_start_idle", 32'(rx_busy), 32'd0);
            check("bad_start_ovf_kept", 32'(err_overflow), 32'd1);
            compare_rx("bad_start");
        end

        // Good frame clears both sticky flags
        fb[0] = 8'($urandom);
        send_frame(1);
        compare_rx("clear");
        check("clear_flags", 32'({err_framing, err_overflow}), 32'd0);

        // Frozen lines mid-byte -> timeout
        send_start(4);
        exp_fs++;
        send_bits(8'($urandom), 5);
        repeat (TIMEOUT - 40) @(negedge clk);
        check("to_still_busy", 32'(rx_busy), 32'd1);
        check("to_no_err_yet", 32'(err_framing), 32'd0);
        repeat (60) @(negedge clk);
        check("to_idle", 32'(rx_busy), 32'd0);
        check("to_framing", 32'(err_framing), 32'd1);
        compare_rx("timeout");
        drive(1'b1, pin5);
        drive(1'b1, 1'b1);
        fb[0] = 8'h12;
        send_frame(1);
        compare_rx("after_to");
        check("after_to_framing", 32'(err_framing), 32'd0);
        check("after_to_data", 32'(fifo_data), 32'h12);

        // Async reset mid-byte, with err_overflow set and the bus busy
        fb[0] = 8'($urandom);
        send_start(4);
        exp_fs++;
        fifo_full = 1'b1;
        send_bits(fb[0], 8);
        fifo_full = 1'b0;
        send_bits(8'($urandom), 3);
        check("pre_rst_busy", 32'(rx_busy), 32'd1);
        check("pre_rst_ovf", 32'(err_overflow), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_data", 32'(fifo_data), 32'd0);
        check("rst_outputs",
              32'({fifo_write, frame_start, frame_end, err_framing, err_overflow}), 32'd0);
        pin1 = 1'b1;
        pin5 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        compare_rx("reset");

        // Disabled through a whole frame
        enable = 1'b0;
        fb[0] = 8'($urandom); fb[1] = 8'($urandom);
        send_start(4);
        check("dis_busy", 32'(rx_busy), 32'd0);
        send_bits(fb[0], 8);
        send_end();
        compare_rx("disabled");
        check("dis_flags", 32'({err_framing, err_overflow}), 32'd0);

        // Enable dropped mid-frame -> silent abort
        enable = 1'b1;
        send_start(4);
        exp_fs++;
        send_bits(8'($urandom), 3);
        check("abort_busy_pre", 32'(rx_busy), 32'd1);
        enable = 1'b0;
        repeat (SLOT) @(negedge clk);
        check("abort_busy", 32'(rx_busy), 32'd0);
        check("abort_flags", 32'({err_framing, err_overflow}), 32'd0);
        drive(1'b1, pin5);
        drive(1'b1, 1'b1);
        compare_rx("abort");

        // Random multi-byte frame
        enable = 1'b1;
        for (int i = 0; i < 3; i++) fb[i] = 8'($urandom);
        send_frame(3);
        compare_rx("rand");
        check("rand_flags", 32'({err_framing, err_overflow}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
